// File: rtl/binary_decoder_scan.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a clocked scan mode.
// Direct mode decodes `a` with one clock of latency. Scan mode walks the active
// line through every output at a rate of one step per SCAN_DIV enabled clocks.
module binary_decoder_scan #(
  parameter int N          = 2,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      a,
  input  logic              load,
  output logic [2**N-1:0]   bcode,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
  localparam logic [W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  // Decoded pattern for one selected line, in the configured polarity.
  function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
    logic [W-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  logic [N-1:0]  idx_d,   idx_q;
  logic [CW-1:0] cnt_d,   cnt_q;
  logic          wrap_d,  wrap_q;
  logic [W-1:0]  bcode_d, bcode_q;

  // Next-state: direct tracking, load, scan stepping and freeze while disabled.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      // Direct mode keeps the divider parked so a later switch to scan
      // starts a full SCAN_DIV period from the current index.
      idx_d = a;
      cnt_d = '0;
    end else if (load) begin
      // Load wins over a coincident step; the step is simply dropped.
      idx_d = a;
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Output is derived from the next index so bcode and idx always agree.
    bcode_d = en ? decode(idx_d) : INACTIVE;
  end

  // State and output registers, cleared asynchronously to the inactive pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      bcode_q <= INACTIVE;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      bcode_q <= bcode_d;
    end
  end

  assign bcode = bcode_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_binary_decoder_scan.sv
// Directed bench for binary_decoder_scan: a 2-bit active-high instance with a
// divide-by-4 scan and a 3-bit active-low instance scanning every clock.
module tb_binary_decoder_scan;

  logic clk = 1'b0;
  logic rst_n;

  logic       en_a, mode_a, load_a;
  logic [1:0] a_a;
  logic [3:0] bcode_a;
  logic [1:0] idx_a;
  logic       wrap_a;

  logic       en_b, mode_b, load_b;
  logic [2:0] a_b;
  logic [7:0] bcode_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_decoder_scan #(.N(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .a(a_a), .load(load_a),
    .bcode(bcode_a), .idx(idx_a), .wrap(wrap_a)
  );

  binary_decoder_scan #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .a(a_b), .load(load_b),
    .bcode(bcode_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full check of instance A against an expected idx and wrap (en assumed 1).
  task automatic chk_a(input string tag, input logic [1:0] ei, input logic ew);
    logic [3:0] oh;
    oh = 4'b0001 << ei;
    chk({tag, ".idx"},   32'(idx_a),   32'(ei));
    chk({tag, ".bcode"}, 32'(bcode_a), 32'(oh));
    chk({tag, ".wrap"},  32'(wrap_a),  32'(ew));
  endtask

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0; mode_a = 1'b0; load_a = 1'b0; a_a = 2'd0;
    en_b   = 1'b0; mode_b = 1'b0; load_b = 1'b0; a_b = 3'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state for both polarities
    chk("rst.a.bcode", 32'(bcode_a), 32'h0);
    chk("rst.a.idx",   32'(idx_a),   32'h0);
    chk("rst.a.wrap",  32'(wrap_a),  32'h0);
    chk("rst.b.bcode", 32'(bcode_b), 32'hff);
    chk("rst.b.wrap",  32'(wrap_b),  32'h0);
    rst_n = 1'b1;

    // Direct sweep
    en_a = 1'b1; mode_a = 1'b0;
    a_a = 2'd0; tick(); chk_a("dir0", 2'd0, 1'b0);
    a_a = 2'd1; tick(); chk_a("dir1", 2'd1, 1'b0);
    a_a = 2'd2; tick(); chk_a("dir2", 2'd2, 1'b0);
    a_a = 2'd3; load_a = 1'b1; tick(); chk_a("dir3", 2'd3, 1'b0);
    load_a = 1'b0;
    en_a = 1'b0; a_a = 2'd1; tick();
    chk("dir_off.bcode", 32'(bcode_a), 32'h0);
    chk("dir_off.idx",   32'(idx_a),   32'h1);

    // Scan from reset: idx 0,1,2,3,0 each held 4 clocks, wrap on 3->0
    rst_n = 1'b0; #1; rst_n = 1'b1;
    mode_a = 1'b1; en_a = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      tick();
      chk_a($sformatf("scan%0d", j), 2'((j / 4) % 4), (j == 16));
    end

    // Reset mid-scan at idx=2, between edges
    repeat (8) tick();
    chk("pre_rst.idx", 32'(idx_a), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.bcode", 32'(bcode_a), 32'h0);
    chk("async_rst.idx",   32'(idx_a),   32'h0);
    chk("async_rst.wrap",  32'(wrap_a),  32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_a("post_rst3", 2'd0, 1'b0);
    tick();
    chk_a("post_rst4", 2'd1, 1'b0);

    // Load priority over a due step (idx=1, divider=3)
    repeat (3) tick();
    chk_a("pre_load", 2'd1, 1'b0);
    load_a = 1'b1; a_a = 2'd3;
    tick();
    chk_a("load", 2'd3, 1'b0);
    load_a = 1'b0; a_a = 2'd0;
    repeat (3) tick();
    chk_a("load+3", 2'd3, 1'b0);
    tick();
    chk_a("load+4", 2'd0, 1'b1);

    // Enable freeze at idx=2, divider=1
    repeat (9) tick();
    chk_a("pre_freeze", 2'd2, 1'b0);
    en_a = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk($sformatf("freeze%0d.bcode", j), 32'(bcode_a), 32'h0);
      chk($sformatf("freeze%0d.idx", j),   32'(idx_a),   32'h2);
      chk($sformatf("freeze%0d.wrap", j),  32'(wrap_a),  32'h0);
    end
    en_a = 1'b1;
    tick(); chk_a("resume1", 2'd2, 1'b0);
    tick(); chk_a("resume2", 2'd2, 1'b0);
    tick(); chk_a("resume3", 2'd3, 1'b0);

    // Mode switches: 1->0 tracks a, 0->1 restarts divider from 0
    mode_a = 1'b0; a_a = 2'd1;
    tick(); chk_a("to_direct", 2'd1, 1'b0);
    mode_a = 1'b1; a_a = 2'd3;
    repeat (3) tick();
    chk_a("to_scan3", 2'd1, 1'b0);
    tick();
    chk_a("to_scan4", 2'd2, 1'b0);

    // Active-low, N=3, SCAN_DIV=1
    mode_b = 1'b0; en_b = 1'b1; a_b = 3'd5;
    tick();
    chk("b.dir5.bcode", 32'(bcode_b), 32'hdf);
    chk("b.dir5.idx",   32'(idx_b),   32'h5);
    mode_b = 1'b1;
    tick();
    chk("b.s6.idx",   32'(idx_b),   32'h6);
    chk("b.s6.bcode", 32'(bcode_b), 32'hbf);
    chk("b.s6.wrap",  32'(wrap_b),  32'h0);
    tick();
    chk("b.s7.idx",   32'(idx_b),   32'h7);
    chk("b.s7.bcode", 32'(bcode_b), 32'h7f);
    chk("b.s7.wrap",  32'(wrap_b),  32'h0);
    tick();
    chk("b.s0.idx",   32'(idx_b),   32'h0);
    chk("b.s0.bcode", 32'(bcode_b), 32'hfe);
    chk("b.s0.wrap",  32'(wrap_b),  32'h1);
    tick();
    chk("b.s1.idx",   32'(idx_b),   32'h1);
    chk("b.s1.wrap",  32'(wrap_b),  32'h0);
    en_b = 1'b0;
    tick();
    chk("b.off.bcode", 32'(bcode_b), 32'hff);
    chk("b.off.idx",   32'(idx_b),   32'h1);
    chk("b.off.wrap",  32'(wrap_b),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
